// File: rtl/bus_pkg.sv
// Shared definitions for the arbitrated 16-bit bus: master-port state
// encoding, the read/write direction constants used by the arbiter, the RAM
// and the master ports, and the default lane widths.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  localparam logic BUS_RW_WRITE = 1'b1;
  localparam logic BUS_RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    BM_IDLE = 2'd0,
    BM_REQ  = 2'd1,
    BM_WAIT = 2'd2,
    BM_RESP = 2'd3
  } bus_master_state_t;

endpackage

// File: rtl/bus_timeout.sv
// Saturating cycle counter with synchronous clear and an expire flag.
// While en is high it counts the cycles spent in some phase; expire is high
// during the LIMIT-th enabled cycle since the last clear, so the owner can
// leave the phase after at most LIMIT cycles.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, counter to 0
//   clr    - synchronous clear, counter to 0 (has priority over counting)
//   en     - count enable
//   expire - combinational, LIMIT-th enabled cycle reached
module bus_timeout #(
  parameter int LIMIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/bus_master_port.sv
// Initiator-side port for the shared arbitrated bus. Takes one read/write
// command at a time from local logic, requests the bus, drives its master
// lane while granted and returns read data or an error as a one-cycle
// response pulse.
//
// Ports:
//   clk, rst                       - clock and synchronous active-high reset
//   cmd_valid_i/cmd_ready_o        - command handshake (ready only when idle)
//   cmd_rw_i, cmd_addr_i, cmd_wdata_i - command direction, address, write data
//   rsp_valid_o, rsp_rdata_o, rsp_error_o - one-cycle completion, data, error
//   barq_o, bagd_i                 - bus request / grant for this lane
//   addr_o, rw_o, data_o           - lane address, direction, write data
//   data_i, data_strobe_i          - shared data bus and data-phase strobe
//   arbiter_error_i                - arbiter-signalled failure
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_rw_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_error_o,
  output logic              barq_o,
  input  logic              bagd_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              rw_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_strobe_i,
  input  logic              arbiter_error_i
);

  bus_master_state_t state, state_nxt;
  logic              err_q, err_nxt;
  logic              accept, on_bus, expire, xfer_ok;

  logic              rw_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p1;

  assign accept  = cmd_valid_i && (state == BM_IDLE);
  assign on_bus  = (state == BM_REQ) || (state == BM_WAIT);
  assign xfer_ok = (state == BM_WAIT) && data_strobe_i && bagd_i && !arbiter_error_i;

  // Priorities: arbiter error > strobe > lost grant / timeout in WAIT;
  // arbiter error / timeout > grant in REQ.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      BM_IDLE: begin
        if (accept) begin
          state_nxt = BM_REQ;
          err_nxt   = 1'b0;
        end
      end
      BM_REQ: begin
        if (arbiter_error_i || expire) begin
          state_nxt = BM_RESP;
          err_nxt   = 1'b1;
        end else if (bagd_i) begin
          state_nxt = BM_WAIT;
        end
      end
      BM_WAIT: begin
        if (arbiter_error_i) begin
          state_nxt = BM_RESP;
          err_nxt   = 1'b1;
        end else if (data_strobe_i && bagd_i) begin
          state_nxt = BM_RESP;
          err_nxt   = 1'b0;
        end else if (!bagd_i || expire) begin
          state_nxt = BM_RESP;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = BM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BM_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // Stage p0: command latched on accept, held for the whole transaction
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_p0    <= cmd_rw_i;
      addr_p0  <= cmd_addr_i;
      wdata_p0 <= cmd_wdata_i;
    end
  end

  // Stage p1: bus data captured in the strobe cycle
  always_ff @(posedge clk) begin
    if (xfer_ok) begin
      rdata_p1 <= data_i;
    end
  end

  // The counter restarts on every state change so REQ and WAIT each get a
  // full TIMEOUT budget.
  bus_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_nxt != state),
    .en     (on_bus),
    .expire (expire)
  );

  // Lane and response outputs are decoded from state, so reset alone
  // forces them to zero without resetting the data registers.
  assign cmd_ready_o = (state == BM_IDLE);
  assign barq_o      = on_bus;
  assign addr_o      = on_bus ? addr_p0  : '0;
  assign rw_o        = on_bus ? rw_p0    : 1'b0;
  assign data_o      = on_bus ? wdata_p0 : '0;
  assign rsp_valid_o = (state == BM_RESP);
  assign rsp_error_o = (state == BM_RESP) && err_q;
  assign rsp_rdata_o = ((state == BM_RESP) && !err_q && (rw_p0 == BUS_RW_READ)) ? rdata_p1 : '0;

endmodule

// File: tb/tb_bus_master_port.sv
module tb_bus_master_port;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_rw    [2];
  logic [15:0] cmd_addr  [2];
  logic [15:0] cmd_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_error [2];
  logic        barq      [2];
  logic        bagd      [2];
  logic [15:0] lane_addr [2];
  logic        lane_rw   [2];
  logic [15:0] lane_data [2];
  logic [15:0] data_bus;
  logic        strobe;
  logic        arb_err;

  bus_master_port #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(10)) u0 (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]), .cmd_rw_i(cmd_rw[0]),
    .cmd_addr_i(cmd_addr[0]), .cmd_wdata_i(cmd_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_error_o(rsp_error[0]),
    .barq_o(barq[0]), .bagd_i(bagd[0]),
    .addr_o(lane_addr[0]), .rw_o(lane_rw[0]), .data_o(lane_data[0]),
    .data_i(data_bus), .data_strobe_i(strobe), .arbiter_error_i(arb_err)
  );

  bus_master_port #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(10)) u1 (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]), .cmd_rw_i(cmd_rw[1]),
    .cmd_addr_i(cmd_addr[1]), .cmd_wdata_i(cmd_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_error_o(rsp_error[1]),
    .barq_o(barq[1]), .bagd_i(bagd[1]),
    .addr_o(lane_addr[1]), .rw_o(lane_rw[1]), .data_o(lane_data[1]),
    .data_i(data_bus), .data_strobe_i(strobe), .arbiter_error_i(arb_err)
  );

  typedef struct {
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int l, input logic err, input logic [15:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    if (l == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Offers one command and advances past the accepting edge.
  task automatic issue(input int l, input logic rw, input logic [15:0] a, input logic [15:0] w,
                       input bit expect_rsp, input logic err, input logic [15:0] rdata);
    check("cmd_ready_before_issue", 16'(cmd_ready[l]), 16'd1);
    if (expect_rsp) push(l, err, rdata);
    cmd_valid[l] = 1'b1;
    cmd_rw[l]    = rw;
    cmd_addr[l]  = a;
    cmd_wdata[l] = w;
    step();
    cmd_valid[l] = 1'b0;
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  exp_t mon_e;
  bit   mon_have;
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rsp_valid[l] === 1'b1) begin
        mon_have = 1'b0;
        if (l == 0 && q0.size() > 0) begin
          mon_e = q0.pop_front();
          mon_have = 1'b1;
        end else if (l == 1 && q1.size() > 0) begin
          mon_e = q1.pop_front();
          mon_have = 1'b1;
        end
        vectors++;
        if (!mon_have) begin
          miscompares++;
          $display("FAIL lane%0d_unexpected_rsp: got rsp_valid=1, expected no response", l);
        end else begin
          if ({rsp_error[l], rsp_rdata[l]} !== {mon_e.err, mon_e.rdata}) begin
            miscompares++;
            $display("FAIL lane%0d_rsp: got err=%0b rdata=0x%04h, expected err=%0b rdata=0x%04h",
                     l, rsp_error[l], rsp_rdata[l], mon_e.err, mon_e.rdata);
          end
        end
        vectors++;
        if (barq[l] !== 1'b0) begin
          miscompares++;
          $display("FAIL lane%0d_barq_in_rsp: got %0b, expected 0", l, barq[l]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < 2; l++) begin
      cmd_valid[l] = 1'b0;
      cmd_rw[l]    = 1'b0;
      cmd_addr[l]  = '0;
      cmd_wdata[l] = '0;
      bagd[l]      = 1'b0;
    end
    data_bus = '0;
    strobe   = 1'b0;
    arb_err  = 1'b0;
    rst      = 1'b1;
    step();
    step();

    // Reset state
    check("rst_cmd_ready", 16'(cmd_ready[0]), 16'd1);
    check("rst_barq",      16'(barq[0]),      16'd0);
    check("rst_addr",      lane_addr[0],      16'h0000);
    check("rst_rw",        16'(lane_rw[0]),   16'd0);
    check("rst_data",      lane_data[0],      16'h0000);
    check("rst_rsp_valid", 16'(rsp_valid[0]), 16'd0);
    check("rst_rsp_rdata", rsp_rdata[0],      16'h0000);
    check("rst_rsp_error", 16'(rsp_error[0]), 16'd0);
    rst = 1'b0;
    step();

    // Write 0x0016 to 0x0014, grant two cycles after request, strobe one later
    issue(0, BUS_RW_WRITE, 16'h0014, 16'h0016, 1'b1, 1'b0, 16'h0000);
    check("wr_barq_c1",  16'(barq[0]),      16'd1);
    check("wr_addr_c1",  lane_addr[0],      16'h0014);
    check("wr_data_c1",  lane_data[0],      16'h0016);
    check("wr_rw_c1",    16'(lane_rw[0]),   16'd1);
    check("wr_ready_c1", 16'(cmd_ready[0]), 16'd0);
    step();
    step();
    bagd[0] = 1'b1;
    check("wr_addr_req", lane_addr[0], 16'h0014);
    step();
    check("wr_barq_wait", 16'(barq[0]), 16'd1);
    check("wr_addr_wait", lane_addr[0], 16'h0014);
    check("wr_data_wait", lane_data[0], 16'h0016);
    strobe = 1'b1;
    step();
    strobe  = 1'b0;
    bagd[0] = 1'b0;
    check("wr_rsp_valid", 16'(rsp_valid[0]), 16'd1);
    check("wr_addr_rsp",  lane_addr[0],      16'h0000);
    check("wr_ready_rsp", 16'(cmd_ready[0]), 16'd0);
    step();
    check("wr_rsp_once",  16'(rsp_valid[0]), 16'd0);
    check("wr_ready_idl", 16'(cmd_ready[0]), 16'd1);

    // Read 0x002C with grant and strobe immediately (minimum latency)
    issue(0, BUS_RW_READ, 16'h002C, 16'hFFFF, 1'b1, 1'b0, 16'h01BC);
    check("rd_rw_c1", 16'(lane_rw[0]), 16'd0);
    bagd[0] = 1'b1;
    step();
    check("rd_addr_wait", lane_addr[0], 16'h002C);
    strobe   = 1'b1;
    data_bus = 16'h01BC;
    step();
    strobe   = 1'b0;
    bagd[0]  = 1'b0;
    data_bus = 16'h0000;
    check("rd_rsp_valid_n3", 16'(rsp_valid[0]), 16'd1);
    check("rd_barq_rsp",     16'(barq[0]),      16'd0);
    step();

    // No grant: timeout response on the 11th cycle after barq rises
    issue(0, BUS_RW_READ, 16'h0030, 16'h0000, 1'b1, 1'b1, 16'h0000);
    for (int i = 1; i <= 10; i++) begin
      check("to_barq_held", 16'(barq[0]), 16'd1);
      step();
    end
    check("to_rsp_valid", 16'(rsp_valid[0]), 16'd1);
    check("to_rsp_error", 16'(rsp_error[0]), 16'd1);
    check("to_barq_drop", 16'(barq[0]),      16'd0);
    step();

    // Grant arriving in the timeout cycle: timeout wins
    issue(0, BUS_RW_READ, 16'h0032, 16'h0000, 1'b1, 1'b1, 16'h0000);
    for (int i = 1; i <= 9; i++) step();
    bagd[0] = 1'b1;
    step();
    bagd[0] = 1'b0;
    check("to_grant_err", 16'(rsp_error[0]), 16'd1);
    step();

    // Arbiter error while waiting for the strobe
    issue(0, BUS_RW_WRITE, 16'h0040, 16'h00AA, 1'b1, 1'b1, 16'h0000);
    bagd[0] = 1'b1;
    step();
    arb_err = 1'b1;
    step();
    arb_err = 1'b0;
    bagd[0] = 1'b0;
    check("ae_rsp_error", 16'(rsp_error[0]), 16'd1);
    step();

    // Arbiter error together with the strobe: error wins, no read data
    issue(0, BUS_RW_READ, 16'h0042, 16'h0000, 1'b1, 1'b1, 16'h0000);
    bagd[0] = 1'b1;
    step();
    strobe   = 1'b1;
    arb_err  = 1'b1;
    data_bus = 16'h1234;
    step();
    strobe   = 1'b0;
    arb_err  = 1'b0;
    bagd[0]  = 1'b0;
    data_bus = 16'h0000;
    check("ae_strobe_rdata", rsp_rdata[0], 16'h0000);
    step();

    // Grant withdrawn before the strobe
    issue(0, BUS_RW_READ, 16'h0044, 16'h0000, 1'b1, 1'b1, 16'h0000);
    bagd[0] = 1'b1;
    step();
    bagd[0] = 1'b0;
    step();
    check("gl_rsp_error", 16'(rsp_error[0]), 16'd1);
    step();

    // Reset in WAIT: lane clears, no response
    issue(0, BUS_RW_WRITE, 16'h0050, 16'h0055, 1'b0, 1'b0, 16'h0000);
    bagd[0] = 1'b1;
    step();
    check("rw_barq_wait", 16'(barq[0]), 16'd1);
    rst = 1'b1;
    step();
    rst     = 1'b0;
    bagd[0] = 1'b0;
    check("rw_barq",      16'(barq[0]),      16'd0);
    check("rw_addr",      lane_addr[0],      16'h0000);
    check("rw_data",      lane_data[0],      16'h0000);
    check("rw_rw",        16'(lane_rw[0]),   16'd0);
    check("rw_rsp_valid", 16'(rsp_valid[0]), 16'd0);
    check("rw_ready",     16'(cmd_ready[0]), 16'd1);
    step();
    step();

    // Two lanes requesting together; arbiter serves lane 0 then lane 1
    push(0, 1'b0, 16'hAAAA);
    push(1, 1'b0, 16'h5555);
    cmd_valid[0] = 1'b1; cmd_rw[0] = BUS_RW_READ; cmd_addr[0] = 16'h0100;
    cmd_valid[1] = 1'b1; cmd_rw[1] = BUS_RW_READ; cmd_addr[1] = 16'h0200;
    step();
    cmd_valid[0] = 1'b0;
    cmd_valid[1] = 1'b0;
    check("mm_barq0", 16'(barq[0]), 16'd1);
    check("mm_barq1", 16'(barq[1]), 16'd1);
    check("mm_addr1", lane_addr[1], 16'h0200);
    bagd[0] = 1'b1;
    step();
    strobe   = 1'b1;
    data_bus = 16'hAAAA;
    step();
    strobe  = 1'b0;
    bagd[0] = 1'b0;
    check("mm_lane1_waiting", 16'(barq[1]),      16'd1);
    check("mm_lane1_no_rsp",  16'(rsp_valid[1]), 16'd0);
    bagd[1] = 1'b1;
    step();
    strobe   = 1'b1;
    data_bus = 16'h5555;
    step();
    strobe   = 1'b0;
    bagd[1]  = 1'b0;
    data_bus = 16'h0000;
    check("mm_lane1_rsp", 16'(rsp_valid[1]), 16'd1);
    step();
    step();

    check("q0_drained", 16'(q0.size()), 16'd0);
    check("q1_drained", 16'(q1.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
# bus_master_port

Initiator-side port for the shared 16-bit arbitrated bus, the counterpart of the arbiter/slave side. It accepts single read/write commands from local logic and raises `barq_o`. Once the arbiter grants `bagd_i`, it holds address, direction and write data on its master lane until the arbiter's `data_strobe_i`, then returns read data or an error. One instance sits per master lane, feeding the bus-side `master_addr_bus[i]`, `master_data_bus[i]`, `master_rw[i]` and `barq[i]` muxes.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `TIMEOUT`, 10: max clk cycles spent in REQ, and separately in WAIT, before local timeout; must be ≥2.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  port idle, command accepted when `cmd_valid_i & cmd_ready_o`.
- `cmd_rw_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  ADDR_W  target address.
- `cmd_wdata_i`  in  DATA_W  write data (ignored on read).
- `rsp_valid_o`  out  1  one-cycle completion pulse.
- `rsp_rdata_o`  out  DATA_W  read data, valid with `rsp_valid_o` on a read without error.
- `rsp_error_o`  out  1  transaction failed, valid with `rsp_valid_o`.
- `barq_o`  out  1  bus request to arbiter.
- `bagd_i`  in  1  grant from arbiter for this lane.
- `addr_o`  out  ADDR_W  lane address.
- `rw_o`  out  1  lane direction.
- `data_o`  out  DATA_W  lane write data.
- `data_i`  in  DATA_W  shared data bus, sampled for reads.
- `data_strobe_i`  in  1  arbiter data strobe, marks the data phase.
- `arbiter_error_i`  in  1  arbiter timeout/error.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `cmd_ready_o`=1. On accept, latch rw/addr/wdata and go to REQ.
- REQ: `barq_o`=1. On `bagd_i`=1, go to WAIT.
- WAIT: `barq_o`=1, hold the grant.
  - On `data_strobe_i`=1 with the grant still held: if read, capture `data_i` into `rsp_rdata_o`. Go to RESP with error=0.
  - On `bagd_i`=0 before the strobe (grant lost): go to RESP with error=1.
- Any state except IDLE/RESP: `arbiter_error_i`=1, or the timeout counter reaching `TIMEOUT`, goes to RESP with error=1. The strobe wins over a timeout in the same cycle; `arbiter_error_i` wins over the strobe.
- RESP: `rsp_valid_o`=1 for exactly one cycle, `barq_o`=0, then IDLE.
- `addr_o`/`rw_o`/`data_o` drive the latched values in REQ and WAIT, and 0 in IDLE/RESP.
- `rsp_rdata_o` is 0 on writes and on errors.
- Timeout counter clears on every state change and counts up while in REQ or WAIT.

## Timing
- Reset: state IDLE. `cmd_ready_o`=1. `barq_o`, `addr_o`, `rw_o`, `data_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_error_o` all 0. Counter 0.
- `rst` mid-transaction: all outputs return to reset values on the next edge and no response is issued; the arbiter sees `barq_o` drop.
- Command accepted at edge N: `barq_o`=1 from N+1.
- `bagd_i` sampled high at edge G: WAIT from G+1.
- `data_strobe_i` sampled high at edge S:
  - `rsp_valid_o`=1 and `barq_o`=0 in cycle S+1.
  - `cmd_ready_o`=1 from S+2.
- Minimum accept-to-response with grant and strobe ready: 3 cycles.
- No back-to-back commands: at most one outstanding transaction per port.
- Grant arriving in the same cycle as a timeout: the timeout wins.

## Structure
- Shared package `bus_pkg`: state enum `bus_master_state_t`, constants `BUS_RW_WRITE`=1'b1 / `BUS_RW_READ`=1'b0, default `BUS_ADDR_W`/`BUS_DATA_W`=16. The arbiter and RAM share the RW constants.
- One sub-module: `bus_timeout`, a parameterised saturating counter with clear and expire output. It is reusable by the arbiter.

## Test plan
- Write: cmd rw=1, addr 0x0014, wdata 0x0016. Grant 2 cycles after `barq_o`, strobe 1 cycle later -> `addr_o`=0x0014 and `data_o`=0x0016 held until the strobe; `rsp_valid_o` pulses once with error=0 and rdata=0.
- Read: addr 0x002C, `data_i`=0x01BC on strobe -> `rsp_rdata_o`=0x01BC, error=0; `barq_o` low in the response cycle.
- No grant for 10 cycles (`TIMEOUT`=10) -> `rsp_error_o`=1 on the 11th cycle after `barq_o` rise; `barq_o` drops.
- Grant then `arbiter_error_i`=1 before the strobe -> error response; a simultaneous strobe and `arbiter_error_i` still gives error=1.
- Grant removed before the strobe -> error=1. `rst` asserted in WAIT -> all outputs 0 next cycle and no `rsp_valid_o`.
- Two masters sharing the arbiter, both requesting -> each completes exactly once, with correct data per lane.
